// File: rtl/writeback_stage_if.sv
// MEM/WB boundary bundle: MEM-stage results going in, register-file write port,
// forwarding tap and retire counter coming out of the write-back stage.
interface writeback_stage_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              MemValid;
    logic              MemRegWrite;
    logic              MemToReg;
    logic              MemLink;
    logic [ADDR_W-1:0] MemWriteReg;
    logic [DATA_W-1:0] MemAluResult;
    logic [DATA_W-1:0] MemReadData;
    logic [DATA_W-1:0] MemPcPlus8;
    logic              Stall;

    logic              RegWrite;
    logic [ADDR_W-1:0] WriteRegister;
    logic [DATA_W-1:0] WriteData;
    logic              BootBusy;
    logic              FwdValid;
    logic [ADDR_W-1:0] FwdReg;
    logic [DATA_W-1:0] FwdData;
    logic [31:0]       RetireCount;

    modport master (
        output MemValid, MemRegWrite, MemToReg, MemLink, MemWriteReg,
               MemAluResult, MemReadData, MemPcPlus8, Stall,
        input  RegWrite, WriteRegister, WriteData, BootBusy,
               FwdValid, FwdReg, FwdData, RetireCount
    );

    modport slave (
        input  MemValid, MemRegWrite, MemToReg, MemLink, MemWriteReg,
               MemAluResult, MemReadData, MemPcPlus8, Stall,
        output RegWrite, WriteRegister, WriteData, BootBusy,
               FwdValid, FwdReg, FwdData, RetireCount
    );
endinterface

// File: rtl/writeback_stage.sv
// Write-back stage: MEM/WB register, result mux, register-file write port with a
// boot-time preload of every architectural register, forwarding tap and retire counter.
module writeback_stage #(
    parameter int              DATA_W    = 32,
    parameter int              ADDR_W    = 5,
    parameter int              NUM_REGS  = 32,
    parameter bit              BOOT_INIT = 1'b1,
    parameter logic [DATA_W-1:0] SP_INIT = 32'h7FFF_EFFC,
    parameter logic [DATA_W-1:0] GP_INIT = 32'h1000_8000
) (
    input  logic               clk,
    input  logic               rst,
    writeback_stage_if.slave   bus
);
    typedef enum logic {BOOT, RUN} state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    state_t              r_state;
    state_t              w_nextState;
    logic [ADDR_W-1:0]   r_bootIdx;
    logic                r_wbValid;
    logic                r_wbDone;
    logic                r_wbRegWrite;
    logic                r_wbToReg;
    logic                r_wbLink;
    logic [ADDR_W-1:0]   r_wbReg;
    logic [DATA_W-1:0]   r_wbAlu;
    logic [DATA_W-1:0]   r_wbRead;
    logic [DATA_W-1:0]   r_wbPc8;
    logic [31:0]         r_retire;
    logic [DATA_W-1:0]   w_wbData;
    logic [DATA_W-1:0]   w_bootData;
    logic                w_firstWb;

    always_ff @(posedge clk) begin
        if (rst) r_state <= (BOOT_INIT != 1'b0) ? BOOT : RUN;
        else     r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        if (r_state == BOOT && r_bootIdx == LAST_IDX) w_nextState = RUN;
    end

    always_ff @(posedge clk) begin
        if (rst)                   r_bootIdx <= '0;
        else if (r_state == BOOT)  r_bootIdx <= r_bootIdx + 1'b1;
    end

    // wb_done marks an entry that already had its write cycle, so a stalled
    // instruction neither writes nor retires a second time.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wbValid <= 1'b0;
            r_wbDone  <= 1'b0;
        end else if (r_state == RUN) begin
            if (!bus.Stall) begin
                r_wbValid    <= bus.MemValid;
                r_wbDone     <= 1'b0;
                r_wbRegWrite <= bus.MemRegWrite;
                r_wbToReg    <= bus.MemToReg;
                r_wbLink     <= bus.MemLink;
                r_wbReg      <= bus.MemWriteReg;
                r_wbAlu      <= bus.MemAluResult;
                r_wbRead     <= bus.MemReadData;
                r_wbPc8      <= bus.MemPcPlus8;
            end else if (r_wbValid) begin
                r_wbDone <= 1'b1;
            end
        end
    end

    assign w_firstWb = (r_state == RUN) && r_wbValid && !r_wbDone;

    always_ff @(posedge clk) begin
        if (rst)            r_retire <= '0;
        else if (w_firstWb) r_retire <= r_retire + 32'd1;
    end

    // Link beats load data, which beats the ALU result.
    always_comb begin
        w_wbData = r_wbAlu;
        if (r_wbLink)       w_wbData = r_wbPc8;
        else if (r_wbToReg) w_wbData = r_wbRead;
    end

    always_comb begin
        w_bootData = '0;
        if (r_bootIdx == ADDR_W'(29))      w_bootData = SP_INIT;
        else if (r_bootIdx == ADDR_W'(28)) w_bootData = GP_INIT;
    end

    always_comb begin
        bus.RegWrite      = 1'b0;
        bus.WriteRegister = r_wbReg;
        bus.WriteData     = w_wbData;
        bus.BootBusy      = 1'b0;
        bus.FwdValid      = 1'b0;
        if (r_state == BOOT) begin
            bus.RegWrite      = 1'b1;
            bus.WriteRegister = r_bootIdx;
            bus.WriteData     = w_bootData;
            bus.BootBusy      = 1'b1;
        end else begin
            bus.FwdValid = r_wbValid && r_wbRegWrite && (r_wbReg != '0);
            bus.RegWrite = bus.FwdValid && !r_wbDone;
        end
    end

    assign bus.FwdReg      = bus.WriteRegister;
    assign bus.FwdData     = bus.WriteData;
    assign bus.RetireCount = r_retire;
endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: boot preload, result mux, $0 suppression,
// stall write-once behaviour, reset mid-boot, and a BOOT_INIT=0 instance.
module tb_writeback_stage;
    logic clk;
    logic rst;
    int   checkCount = 0;
    int   passCount  = 0;
    int   failCount  = 0;
    logic monitorOn  = 1'b0;
    logic busy0Seen  = 1'b0;

    writeback_stage_if #(.DATA_W(32), .ADDR_W(5)) bus  ();
    writeback_stage_if #(.DATA_W(32), .ADDR_W(5)) bus0 ();

    writeback_stage #(.BOOT_INIT(1'b1)) dut  (.clk(clk), .rst(rst), .bus(bus.slave));
    writeback_stage #(.BOOT_INIT(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (monitorOn && bus0.BootBusy) busy0Seen = 1'b1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic rw, input logic toReg, input logic link,
                                 input logic [4:0] rd, input logic [31:0] alu,
                                 input logic [31:0] load, input logic [31:0] pc8, input logic stall);
        bus.MemValid     = v;
        bus.MemRegWrite  = rw;
        bus.MemToReg     = toReg;
        bus.MemLink      = link;
        bus.MemWriteReg  = rd;
        bus.MemAluResult = alu;
        bus.MemReadData  = load;
        bus.MemPcPlus8   = pc8;
        bus.Stall        = stall;
    endtask

    initial begin
        logic [31:0] expData;
        rst = 1'b0;
        applyStimulus(0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 32'h0, 0);
        bus0.MemValid = 0; bus0.MemRegWrite = 0; bus0.MemToReg = 0; bus0.MemLink = 0;
        bus0.MemWriteReg = '0; bus0.MemAluResult = '0; bus0.MemReadData = '0;
        bus0.MemPcPlus8 = '0; bus0.Stall = 0;

        // Reset, then the full boot preload with junk MEM traffic that must be ignored
        rst = 1'b1;
        tick();
        rst = 1'b0;
        monitorOn = 1'b1;
        applyStimulus(1, 1, 0, 0, 5'd7, 32'hBAD0BAD0, 32'h0, 32'h0, 1);
        checkOutput("reset_retire", bus.RetireCount, 32'd0);
        for (int i = 0; i < 32; i++) begin
            expData = (i == 29) ? 32'h7FFF_EFFC : (i == 28) ? 32'h1000_8000 : 32'h0;
            checkOutput($sformatf("boot_we_%0d", i), {31'b0, bus.RegWrite}, 32'd1);
            checkOutput($sformatf("boot_addr_%0d", i), {27'b0, bus.WriteRegister}, i);
            checkOutput($sformatf("boot_data_%0d", i), bus.WriteData, expData);
            checkOutput($sformatf("boot_busy_%0d", i), {31'b0, bus.BootBusy}, 32'd1);
            tick();
        end
        checkOutput("run_busy", {31'b0, bus.BootBusy}, 32'd0);
        checkOutput("run_first_we", {31'b0, bus.RegWrite}, 32'd0);
        checkOutput("run_first_fwd", {31'b0, bus.FwdValid}, 32'd0);
        checkOutput("run_first_retire", bus.RetireCount, 32'd0);

        // ALU result to reg 8
        applyStimulus(1, 1, 0, 0, 5'd8, 32'h1234_5678, 32'h0, 32'h0, 0);
        tick();
        checkOutput("alu_we", {31'b0, bus.RegWrite}, 32'd1);
        checkOutput("alu_addr", {27'b0, bus.WriteRegister}, 32'd8);
        checkOutput("alu_data", bus.WriteData, 32'h1234_5678);
        checkOutput("alu_fwd", {31'b0, bus.FwdValid}, 32'd1);
        checkOutput("alu_retire", bus.RetireCount, 32'd0);

        // Load data to reg 9
        applyStimulus(1, 1, 1, 0, 5'd9, 32'h1111_1111, 32'hDEAD_BEEF, 32'h0, 0);
        tick();
        checkOutput("load_retire", bus.RetireCount, 32'd1);
        checkOutput("load_addr", {27'b0, bus.WriteRegister}, 32'd9);
        checkOutput("load_data", bus.WriteData, 32'hDEAD_BEEF);

        // Link overrides load select
        applyStimulus(1, 1, 1, 1, 5'd31, 32'h2222_2222, 32'h3333_3333, 32'h0040_0010, 0);
        tick();
        checkOutput("link_addr", {27'b0, bus.WriteRegister}, 32'd31);
        checkOutput("link_data", bus.WriteData, 32'h0040_0010);
        checkOutput("link_we", {31'b0, bus.RegWrite}, 32'd1);
        checkOutput("link_retire", bus.RetireCount, 32'd2);

        // Write to $0 is suppressed but still retires
        applyStimulus(1, 1, 0, 0, 5'd0, 32'h0000_AAAA, 32'h0, 32'h0, 0);
        tick();
        checkOutput("zero_we", {31'b0, bus.RegWrite}, 32'd0);
        checkOutput("zero_fwd", {31'b0, bus.FwdValid}, 32'd0);
        checkOutput("zero_retire", bus.RetireCount, 32'd3);

        // Reg 5 then a 3-cycle stall with changing MEM inputs
        applyStimulus(1, 1, 0, 0, 5'd5, 32'h55AA_55AA, 32'h0, 32'h0, 0);
        tick();
        checkOutput("stall0_we", {31'b0, bus.RegWrite}, 32'd1);
        checkOutput("stall0_fwd", {31'b0, bus.FwdValid}, 32'd1);
        checkOutput("stall0_fdata", bus.FwdData, 32'h55AA_55AA);
        checkOutput("stall0_retire", bus.RetireCount, 32'd4);
        applyStimulus(1, 1, 0, 0, 5'd6, 32'h0000_0001, 32'h0, 32'h0, 1);
        for (int s = 1; s <= 3; s++) begin
            tick();
            checkOutput($sformatf("stall%0d_we", s), {31'b0, bus.RegWrite}, 32'd0);
            checkOutput($sformatf("stall%0d_fwd", s), {31'b0, bus.FwdValid}, 32'd1);
            checkOutput($sformatf("stall%0d_freg", s), {27'b0, bus.FwdReg}, 32'd5);
            checkOutput($sformatf("stall%0d_fdata", s), bus.FwdData, 32'h55AA_55AA);
            checkOutput($sformatf("stall%0d_retire", s), bus.RetireCount, 32'd5);
        end

        // Release the stall with a valid non-writing instruction
        applyStimulus(1, 0, 0, 0, 5'd12, 32'h0, 32'h0, 32'h0, 0);
        tick();
        checkOutput("nowr_we", {31'b0, bus.RegWrite}, 32'd0);
        checkOutput("nowr_fwd", {31'b0, bus.FwdValid}, 32'd0);
        checkOutput("nowr_retire_a", bus.RetireCount, 32'd5);
        applyStimulus(0, 1, 0, 0, 5'd13, 32'h0, 32'h0, 32'h0, 0);
        tick();
        checkOutput("nowr_retire_b", bus.RetireCount, 32'd6);
        checkOutput("bubble_we", {31'b0, bus.RegWrite}, 32'd0);

        // Reset in RUN, then reset again at boot index 10
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("rerun_retire", bus.RetireCount, 32'd0);
        checkOutput("rerun_busy", {31'b0, bus.BootBusy}, 32'd1);
        for (int i = 0; i < 10; i++) tick();
        checkOutput("idx10_addr", {27'b0, bus.WriteRegister}, 32'd10);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("restart_addr", {27'b0, bus.WriteRegister}, 32'd0);
        checkOutput("restart_we", {31'b0, bus.RegWrite}, 32'd1);

        // BOOT_INIT=0 instance is already in RUN with an empty WB register
        checkOutput("nb_first_we", {31'b0, bus0.RegWrite}, 32'd0);
        checkOutput("nb_first_fwd", {31'b0, bus0.FwdValid}, 32'd0);
        bus0.MemValid = 1; bus0.MemRegWrite = 1; bus0.MemWriteReg = 5'd3;
        bus0.MemAluResult = 32'hCAFE_F00D;
        tick();
        bus0.MemValid = 0;
        checkOutput("nb_we", {31'b0, bus0.RegWrite}, 32'd1);
        checkOutput("nb_addr", {27'b0, bus0.WriteRegister}, 32'd3);
        checkOutput("nb_data", bus0.WriteData, 32'hCAFE_F00D);

        for (int i = 1; i < 31; i++) tick();
        checkOutput("reboot_last_addr", {27'b0, bus.WriteRegister}, 32'd31);
        checkOutput("reboot_last_busy", {31'b0, bus.BootBusy}, 32'd1);
        tick();
        checkOutput("reboot_done_busy", {31'b0, bus.BootBusy}, 32'd0);
        checkOutput("reboot_done_we", {31'b0, bus.RegWrite}, 32'd0);
        checkOutput("nb_retire", bus0.RetireCount, 32'd1);
        checkOutput("nb_never_busy", {31'b0, busy0Seen}, 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Writer side of the pipeline register file: holds the MEM/WB pipeline register, selects the write-back value, and drives the register-file write port (RegWrite, WriteRegister, WriteData).
- After reset, a boot FSM preloads every architectural register through the same write port, so the file needs no simulation-only initialisation.
- Also exports a WB-stage forwarding tap for the EX-stage forwarding unit and a retired-instruction counter.

Parameters:
- DATA_W, 32, datapath width.
- ADDR_W, 5, register address width.
- NUM_REGS, 32, registers preloaded at boot.
- BOOT_INIT, 1, 1 = run the boot preload after reset; 0 = enter RUN directly.
- SP_INIT, 32'h7FFF_EFFC, boot value for $29.
- GP_INIT, 32'h1000_8000, boot value for $28.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- MemValid  in  1  MEM stage holds a real instruction.
- MemRegWrite  in  1  instruction writes a register.
- MemToReg  in  1  select load data.
- MemLink  in  1  jal/jalr: select PC+8.
- MemWriteReg  in  ADDR_W  destination register.
- MemAluResult  in  DATA_W  ALU result.
- MemReadData  in  DATA_W  data-memory load result.
- MemPcPlus8  in  DATA_W  link value.
- Stall  in  1  hold the WB register.
- RegWrite  out  1  register-file write enable.
- WriteRegister  out  ADDR_W  register-file write address.
- WriteData  out  DATA_W  register-file write data.
- BootBusy  out  1  boot preload in progress; upstream must treat it as a stall.
- FwdValid  out  1  WB-stage forwarding tap is valid.
- FwdReg  out  ADDR_W  forwarding tap register.
- FwdData  out  DATA_W  forwarding tap data.
- RetireCount  out  32  count of retired instructions.

Behaviour:
- Reset (rst=1 at an edge):
  - wb_valid=0, wb_done=0, boot index=0, RetireCount=0.
  - State becomes BOOT if BOOT_INIT=1, else RUN.
  - RegWrite and FwdValid are 0 in the first RUN cycle after reset.
  - rst during BOOT restarts the preload from index 0.
- State machine: BOOT -> RUN only. RUN persists until rst.
- BOOT:
  - Each cycle: RegWrite=1, WriteRegister=index, WriteData = SP_INIT for 29, GP_INIT for 28, else 0.
  - Index increments each cycle. After index NUM_REGS-1 is written, the next state is RUN.
  - BootBusy=1 throughout BOOT. All MEM inputs are ignored and the WB register stays invalid.
  - Boot takes exactly NUM_REGS cycles.
- MEM/WB register (RUN), updated at each edge:
  - Stall=1: hold the contents.
  - Stall=0: capture all Mem* inputs; wb_valid = MemValid.
  - The register is a plain flop stage; it never bypasses its own input.
- Write-back mux, priority order: MemLink -> PcPlus8; else MemToReg -> ReadData; else AluResult. Full DATA_W width, no extension.
- Write port (RUN):
  - RegWrite = wb_valid & wb_regwrite & (wb_reg != 0) & !wb_done.
  - WriteRegister and WriteData come from the WB register and mux.
  - Writes to $0 are always suppressed in RUN. Boot writes 0 to $0.
- Latency: MEM values captured at edge N are written at edge N+1.
- wb_done:
  - Set at the edge that ends an entry's first WB cycle while Stall=1.
  - Cleared when a new entry is captured.
  - A held entry therefore writes exactly once.
- Forwarding tap:
  - FwdValid = RUN & wb_valid & wb_regwrite & wb_reg != 0. It ignores wb_done, so the tap stays valid across a stall.
  - FwdReg and FwdData equal the write address and data.
- RetireCount:
  - +1 on each entry's first WB cycle with wb_valid=1, including non-writing and $0 instructions.
  - Not counted again while held. Wraps modulo 2^32. Never counts during BOOT.
- Simultaneous events: rst beats everything. Stall during BOOT has no effect.

Test Plan:
- rst pulse, BOOT_INIT=1 -> 32 cycles of RegWrite=1 with WriteRegister 0..31. WriteData=0x7FFFEFFC at 29, 0x10008000 at 28, 0 elsewhere. BootBusy drops on cycle 33. RetireCount=0.
- RUN, MemValid=1, MemRegWrite=1, MemWriteReg=8, MemAluResult=0x12345678 -> next cycle RegWrite=1, WriteRegister=8, WriteData=0x12345678, FwdValid=1. RetireCount 0->1.
- MemToReg=1, MemReadData=0xDEADBEEF, reg 9 -> WriteData=0xDEADBEEF. Then MemLink=1 and MemToReg=1, reg 31, PcPlus8=0x00400010 -> WriteData=0x00400010.
- MemWriteReg=0, MemRegWrite=1 -> RegWrite=0 and FwdValid=0; RetireCount still increments.
- Valid write to reg 5, then Stall held 3 cycles -> RegWrite high in the first cycle only. FwdValid=1 with FwdData constant for all 4 cycles. RetireCount +1 total.
- rst asserted at boot index 10 -> next cycle WriteRegister=0 and boot completes 32 cycles later. Same sequence with BOOT_INIT=0 -> BootBusy never asserts.
